// File: rtl/counter_mod_n_pkg.sv
// Shared definitions for the modulo-N counter: parameter legality helper.
package counter_mod_n_pkg;

    // True when 2 <= n <= 2**w; evaluated at elaboration to reject bad moduli.
    function automatic bit modulus_ok(input int n, input int w);
        return (n >= 2) && (w >= 1) && (longint'(n) <= (longint'(1) << w));
    endfunction

endpackage

// File: rtl/counter_mod_n.sv
// Synchronous modulo-N up-counter with enable and a combinational terminal-count strobe.
module counter_mod_n
    import counter_mod_n_pkg::*;
#(
    parameter int N         = 10,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] counter_out,
    output logic                 tc
);

    generate
        if (!modulus_ok(N, CNT_WIDTH)) begin : g_bad_param
            $error("counter_mod_n: N=%0d outside 2..2**CNT_WIDTH (CNT_WIDTH=%0d)", N, CNT_WIDTH);
        end
    endgenerate

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N - 1);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_is_last;
    logic                 w_wrap;

    assign w_is_last = (r_count == LAST);
    // Wrap on >= so a stray power-up value above N-1 falls back to 0.
    assign w_wrap    = (r_count >= LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (enable) begin
            if (w_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign counter_out = r_count;
    assign tc          = enable & w_is_last;

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed self-checking bench for counter_mod_n at N=10, N=16 and N=2.
module tb_counter_mod_n;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] cnt10;
    logic       tc10;
    logic [3:0] cnt16;
    logic       tc16;
    logic [0:0] cnt2;
    logic       tc2;

    int errors;
    int checks;

    counter_mod_n #(.N(10), .CNT_WIDTH(4)) u_mod10 (
        .clk(clk), .reset(reset), .enable(enable), .counter_out(cnt10), .tc(tc10)
    );
    counter_mod_n #(.N(16), .CNT_WIDTH(4)) u_mod16 (
        .clk(clk), .reset(reset), .enable(enable), .counter_out(cnt16), .tc(tc16)
    );
    counter_mod_n #(.N(2), .CNT_WIDTH(1)) u_mod2 (
        .clk(clk), .reset(reset), .enable(enable), .counter_out(cnt2), .tc(tc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (cnt10 !== 4'd0) begin
                errors++;
                $display("FAIL reset_cnt10 cycle %0d: got %0d expected 0", i, cnt10);
            end
        end
        checks++;
        if (cnt16 !== 4'd0 || cnt2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_others: cnt16=%0d cnt2=%0d expected 0 0", cnt16, cnt2);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cnt10 !== 4'd0 || tc10 !== 1'b0) begin
                errors++;
                $display("FAIL hold_after_reset cycle %0d: cnt=%0d tc=%0b expected 0 0", i, cnt10, tc10);
            end
        end
    endtask

    task automatic test_full_sequence();
        int exp_cnt;
        int prev;
        do_reset();
        enable = 1'b1;
        prev   = 0;
        for (int i = 1; i <= 14; i++) begin
            #1;
            checks++;
            if (tc10 !== (prev == 9)) begin
                errors++;
                $display("FAIL seq_tc before edge %0d: got %0b expected %0b (count %0d)", i, tc10, (prev == 9), prev);
            end
            tick();
            exp_cnt = i % 10;
            checks++;
            if (cnt10 !== exp_cnt[3:0]) begin
                errors++;
                $display("FAIL seq_cnt edge %0d: got %0d expected %0d", i, cnt10, exp_cnt);
            end
            prev = exp_cnt;
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_gating();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (cnt10 !== 4'd5) begin
            errors++;
            $display("FAIL gate_run5: got %0d expected 5", cnt10);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cnt10 !== 4'd5) begin
                errors++;
                $display("FAIL gate_hold cycle %0d: got %0d expected 5", i, cnt10);
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if (cnt10 !== 4'd6) begin
            errors++;
            $display("FAIL gate_resume1: got %0d expected 6", cnt10);
        end
        tick();
        checks++;
        if (cnt10 !== 4'd7) begin
            errors++;
            $display("FAIL gate_resume2: got %0d expected 7", cnt10);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_priority();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (cnt10 !== 4'd7) begin
            errors++;
            $display("FAIL prio_reach7: got %0d expected 7", cnt10);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (cnt10 !== 4'd0) begin
            errors++;
            $display("FAIL prio_reset: got %0d expected 0", cnt10);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (cnt10 !== 4'd1) begin
            errors++;
            $display("FAIL prio_resume: got %0d expected 1", cnt10);
        end
        enable = 1'b0;
    endtask

    task automatic test_pow2();
        int tc_pulses;
        int exp_cnt;
        do_reset();
        enable    = 1'b1;
        tc_pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            if (tc16 === 1'b1) tc_pulses++;
            if (i == 16) begin
                checks++;
                if (cnt16 !== 4'd15 || tc16 !== 1'b1) begin
                    errors++;
                    $display("FAIL pow2_at15: cnt=%0d tc=%0b expected 15 1", cnt16, tc16);
                end
            end
            tick();
            exp_cnt = i % 16;
            checks++;
            if (cnt16 !== exp_cnt[3:0]) begin
                errors++;
                $display("FAIL pow2_cnt edge %0d: got %0d expected %0d", i, cnt16, exp_cnt);
            end
        end
        checks++;
        if (tc_pulses != 1) begin
            errors++;
            $display("FAIL pow2_tc_pulses: got %0d expected 1", tc_pulses);
        end
        enable = 1'b0;
    endtask

    task automatic test_min_modulus();
        logic [0:0] exp_cnt;
        logic [0:0] prev;
        do_reset();
        enable = 1'b1;
        prev   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (tc2 !== prev) begin
                errors++;
                $display("FAIL min_tc before edge %0d: got %0b expected %0b", i, tc2, prev);
            end
            tick();
            exp_cnt = (i % 2 == 1) ? 1'b1 : 1'b0;
            checks++;
            if (cnt2 !== exp_cnt) begin
                errors++;
                $display("FAIL min_cnt edge %0d: got %0b expected %0b", i, cnt2, exp_cnt);
            end
            prev = exp_cnt;
        end
        tick();
        enable = 1'b0;
        #1;
        checks++;
        if (cnt2 !== 1'b1 || tc2 !== 1'b0) begin
            errors++;
            $display("FAIL min_tc_gated: cnt=%0b tc=%0b expected 1 0", cnt2, tc2);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        enable = 1'b0;
        test_reset();
        test_full_sequence();
        test_enable_gating();
        test_reset_priority();
        test_pow2();
        test_min_modulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
